uart_mmio_responder: RTL and testbench

//  Bus-side responder for the UART window of the data memory map. It decodes CPU

---
 rtl/uart_mmio_responder.sv | 207 ++++++++++++++++++++
 tb/tb_uart_mmio_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_responder.sv
// Memory-mapped UART responder: decodes five registers in the data map, drives an
// 8N1 transmitter and a mid-bit-sampling receiver, and answers loads combinationally.
module uart_mmio_responder #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115_200,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       addr,
   input  logic              we,
   input  logic              re,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              hit,
   input  logic              uart_rx,
   output logic              uart_tx
);

   localparam int CPB = CLK_FREQ / BAUD;
   localparam int CW  = $clog2(CPB);
   localparam logic [CW-1:0] BIT_LAST = CW'(CPB - 1);
   localparam logic [CW-1:0] BIT_HALF = CW'(CPB / 2);

   localparam logic [31:0] A_TX      = 32'h1001_0100;
   localparam logic [31:0] A_RX      = 32'h1001_0104;
   localparam logic [31:0] A_TX_DONE = 32'h1001_0102;
   localparam logic [31:0] A_BUSY    = 32'h1001_0108;
   localparam logic [31:0] A_RX_DONE = 32'h1001_010c;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic sel_tx, sel_rx, sel_txd, sel_busy, sel_rxd;
   logic unused_wdata;

   assign sel_tx       = (addr == A_TX);
   assign sel_rx       = (addr == A_RX);
   assign sel_txd      = (addr == A_TX_DONE);
   assign sel_busy     = (addr == A_BUSY);
   assign sel_rxd      = (addr == A_RX_DONE);
   assign hit          = sel_tx | sel_rx | sel_txd | sel_busy | sel_rxd;
   assign unused_wdata = ^wdata[DATA_W-1:8];

   // ---------------- transmitter ----------------
   state_t        tx_state, tx_state_n;
   logic [CW-1:0] tx_cnt, tx_cnt_n;
   logic [2:0]    tx_idx, tx_idx_n;
   logic [7:0]    tx_shift, tx_shift_n;
   logic          tx_line_n, tx_busy, tx_busy_n, tx_done, tx_done_n;
   logic          tx_bit_end;

   assign tx_bit_end = (tx_cnt == BIT_LAST);

   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_idx_n   = tx_idx;
      tx_shift_n = tx_shift;
      tx_line_n  = uart_tx;
      tx_busy_n  = tx_busy;
      tx_done_n  = tx_done;
      if (we && sel_txd && !wdata[0])
         tx_done_n = 1'b0;
      // completion below is assigned after the clear so it wins a same-cycle clash
      case (tx_state)
         IDLE: if (we && sel_tx) begin
            tx_state_n = START;
            tx_shift_n = wdata[7:0];
            tx_busy_n  = 1'b1;
            tx_done_n  = 1'b0;
            tx_line_n  = 1'b0;
            tx_cnt_n   = '0;
         end
         START: if (tx_bit_end) begin
            tx_state_n = DATA;
            tx_cnt_n   = '0;
            tx_idx_n   = '0;
            tx_line_n  = tx_shift[0];
         end else begin
            tx_cnt_n = tx_cnt + CW'(1);
         end
         DATA: if (tx_bit_end) begin
            tx_cnt_n = '0;
            if (tx_idx == 3'd7) begin
               tx_state_n = STOP;
               tx_line_n  = 1'b1;
            end else begin
               tx_idx_n   = tx_idx + 3'd1;
               tx_line_n  = tx_shift[1];
               tx_shift_n = {1'b0, tx_shift[7:1]};
            end
         end else begin
            tx_cnt_n = tx_cnt + CW'(1);
         end
         STOP: if (tx_bit_end) begin
            tx_state_n = IDLE;
            tx_cnt_n   = '0;
            tx_busy_n  = 1'b0;
            tx_done_n  = 1'b1;
         end else begin
            tx_cnt_n = tx_cnt + CW'(1);
         end
         default: tx_state_n = IDLE;
      endcase
   end

   // ---------------- receiver ----------------
   logic          rx_meta, rx_s, rx_prev;
   state_t        rx_state, rx_state_n;
   logic [CW-1:0] rx_cnt, rx_cnt_n;
   logic [2:0]    rx_idx, rx_idx_n;
   logic [7:0]    rx_shift, rx_shift_n, rx_data, rx_data_n;
   logic          rx_done, rx_done_n;

   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt;
      rx_idx_n   = rx_idx;
      rx_shift_n = rx_shift;
      rx_data_n  = rx_data;
      rx_done_n  = rx_done;
      if ((re && sel_rx) || (we && sel_rxd && !wdata[0]))
         rx_done_n = 1'b0;
      case (rx_state)
         IDLE: if (rx_prev && !rx_s) begin
            rx_state_n = START;
            rx_cnt_n   = '0;
         end
         START: if (rx_cnt == BIT_HALF) begin
            // a start bit that is high again at mid-bit was only a glitch
            rx_state_n = rx_s ? IDLE : DATA;
            rx_cnt_n   = '0;
            rx_idx_n   = '0;
         end else begin
            rx_cnt_n = rx_cnt + CW'(1);
         end
         DATA: if (rx_cnt == BIT_LAST) begin
            rx_cnt_n   = '0;
            rx_shift_n = {rx_s, rx_shift[7:1]};
            if (rx_idx == 3'd7)
               rx_state_n = STOP;
            else
               rx_idx_n = rx_idx + 3'd1;
         end else begin
            rx_cnt_n = rx_cnt + CW'(1);
         end
         STOP: if (rx_cnt == BIT_LAST) begin
            rx_state_n = IDLE;
            rx_cnt_n   = '0;
            if (rx_s) begin
               rx_data_n = rx_shift;
               rx_done_n = 1'b1;
            end
         end else begin
            rx_cnt_n = rx_cnt + CW'(1);
         end
         default: rx_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_shift <= '0;
         uart_tx  <= 1'b1;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
         rx_meta  <= 1'b1;
         rx_s     <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= IDLE;
         rx_cnt   <= '0;
         rx_idx   <= '0;
         rx_shift <= '0;
         rx_data  <= '0;
         rx_done  <= 1'b0;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_idx   <= tx_idx_n;
         tx_shift <= tx_shift_n;
         uart_tx  <= tx_line_n;
         tx_busy  <= tx_busy_n;
         tx_done  <= tx_done_n;
         rx_meta  <= uart_rx;
         rx_s     <= rx_meta;
         rx_prev  <= rx_s;
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_idx   <= rx_idx_n;
         rx_shift <= rx_shift_n;
         rx_data  <= rx_data_n;
         rx_done  <= rx_done_n;
      end
   end

   always_comb begin
      rdata = '0;
      if (sel_rx)   rdata[7:0] = rx_data;
      if (sel_txd)  rdata[0]   = tx_done;
      if (sel_busy) rdata[0]   = tx_busy;
      if (sel_rxd)  rdata[0]   = rx_done;
   end

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Randomized scoreboard bench for uart_mmio_responder: a time-based register/line
// model predicts every load and every uart_tx cycle; monitors compare on negedge.
module tb_uart_mmio_responder;

   localparam int FRAME = 160;
   localparam logic [31:0] A_TX   = 32'h1001_0100;
   localparam logic [31:0] A_RX   = 32'h1001_0104;
   localparam logic [31:0] A_TXD  = 32'h1001_0102;
   localparam logic [31:0] A_BUSY = 32'h1001_0108;
   localparam logic [31:0] A_RXD  = 32'h1001_010c;

   logic        clk = 1'b0, rst = 1'b1, we = 1'b0, re = 1'b0, uart_rx = 1'b1;
   logic [31:0] addr = '0, wdata = '0, rdata;
   logic        hit, uart_tx;

   uart_mmio_responder #(.CLK_FREQ(16), .BAUD(1), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .addr(addr), .we(we), .re(re), .wdata(wdata),
      .rdata(rdata), .hit(hit), .uart_rx(uart_rx), .uart_tx(uart_tx));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, errors = 0;

   typedef struct {logic [31:0] a; logic [31:0] d; logic h;} rd_t;
   typedef struct {int c; logic v;} ln_t;
   rd_t rd_q[$];
   ln_t ln_q[$];
   rd_t mon_r;
   ln_t mon_l;

   // reference model state: TX described by frame start edge, flags by event edges
   int         tx_start = -1, tx_clr = -1;
   logic [7:0] rx_data_m = '0;
   bit         rx_done_m = 1'b0;
   logic [31:0] near_miss [5] = '{32'h1001_0101, 32'h1001_0110, 32'h0001_0100,
                                  32'h1001_0103, 32'h9001_0104};

   always @(negedge clk) begin
      if (re) begin
         checks++;
         if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected addr=%h rdata=%h", addr, rdata);
         end else begin
            mon_r = rd_q.pop_front();
            if (rdata !== mon_r.d || hit !== mon_r.h) begin
               errors++;
               $display("FAIL rd addr=%h cyc=%0d got rdata=%h hit=%b want rdata=%h hit=%b",
                        mon_r.a, cyc, rdata, hit, mon_r.d, mon_r.h);
            end
         end
      end
      while (ln_q.size() > 0 && ln_q[0].c <= cyc) begin
         mon_l = ln_q.pop_front();
         checks++;
         if (mon_l.c != cyc || uart_tx !== mon_l.v) begin
            errors++;
            $display("FAIL tx_line cyc=%0d slot=%0d got %b want %b", cyc, mon_l.c, uart_tx, mon_l.v);
         end
      end
   end

   function automatic bit m_busy(int m);
      return tx_start >= 0 && m >= tx_start && m < tx_start + FRAME;
   endfunction

   function automatic bit m_done(int m);
      return tx_start >= 0 && m >= tx_start + FRAME && !(tx_clr > tx_start + FRAME && m >= tx_clr);
   endfunction

   function automatic logic line_bit(logic [7:0] b, int k);
      int i;
      i = k / 16;
      if (i == 0) return 1'b0;
      if (i == 9) return 1'b1;
      return b[i-1];
   endfunction

   function automatic logic [31:0] exp_rd(logic [31:0] a, int m);
      if (a == A_RX)   return {24'b0, rx_data_m};
      if (a == A_TXD)  return {31'b0, m_done(m)};
      if (a == A_BUSY) return {31'b0, m_busy(m)};
      if (a == A_RXD)  return {31'b0, rx_done_m};
      return 32'h0;
   endfunction

   function automatic logic is_hit(logic [31:0] a);
      return a == A_TX || a == A_RX || a == A_TXD || a == A_BUSY || a == A_RXD;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      re = 1'b0;
      we = 1'b0;
   endtask

   task automatic load(input logic [31:0] a);
      rd_t e;
      e.a = a; e.d = exp_rd(a, cyc); e.h = is_hit(a);
      rd_q.push_back(e);
      if (a == A_RX) rx_done_m = 1'b0;
      addr = a; re = 1'b1;
      tick();
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      ln_t l;
      if (a == A_TX && !m_busy(cyc)) begin
         tx_start = cyc + 1;
         l.c = cyc; l.v = 1'b1; ln_q.push_back(l);
         for (int k = 0; k < FRAME; k++) begin
            l.c = cyc + 1 + k; l.v = line_bit(d[7:0], k); ln_q.push_back(l);
         end
         l.c = cyc + 1 + FRAME; l.v = 1'b1; ln_q.push_back(l);
      end
      if (a == A_TXD && !d[0] && cyc + 1 > tx_clr) tx_clr = cyc + 1;
      if (a == A_RXD && !d[0]) rx_done_m = 1'b0;
      addr = a; wdata = d; we = 1'b1;
      tick();
   endtask

   task automatic do_reset();
      ln_t l;
      while (ln_q.size() > 0 && ln_q[ln_q.size()-1].c > cyc) void'(ln_q.pop_back());
      l.c = cyc + 1; l.v = 1'b1; ln_q.push_back(l);
      tx_start = -1; tx_clr = -1; rx_data_m = '0; rx_done_m = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   function automatic logic [31:0] pick_addr();
      case ($urandom_range(0, 5))
         0: return A_TX;
         1: return A_RX;
         2: return A_TXD;
         3: return A_BUSY;
         4: return A_RXD;
         default: return near_miss[$urandom_range(0, 4)];
      endcase
   endfunction

   task automatic rand_store();
      case ($urandom_range(0, 3))
         0: store(A_TX, $urandom);
         1: store(A_TXD, {31'b0, 1'($urandom_range(0, 1))});
         2: store(A_RXD, {31'b0, 1'($urandom_range(0, 1))});
         default: store(near_miss[$urandom_range(0, 4)], $urandom);
      endcase
   endtask

   // lvl 0: idle only, 1: random loads, 2: random loads and stores
   task automatic run_to(input int target, input int lvl);
      int r;
      while (cyc < target) begin
         r = $urandom_range(0, 15);
         if (lvl >= 1 && r < 4) load(pick_addr());
         else if (lvl >= 2 && r == 4) rand_store();
         else tick();
      end
   endtask

   task automatic send_rx(input logic [7:0] b, input bit stop_ok, input bit ld_at_stop);
      int bi;
      for (int t = 0; t < FRAME; t++) begin
         bi = t / 16;
         if (bi == 0) uart_rx = 1'b0;
         else if (bi == 9) uart_rx = stop_ok;
         else uart_rx = b[bi-1];
         if (ld_at_stop && t == 155) load(A_RX);
         else tick();
      end
      uart_rx = 1'b1;
      if (stop_ok) begin
         rx_data_m = b;
         rx_done_m = 1'b1;
      end
      repeat (3) tick();
   endtask

   initial begin
      int s;
      tick(); tick();
      do_reset();
      // reset state
      load(A_TX); load(A_RX); load(A_TXD); load(A_BUSY); load(A_RXD); load(near_miss[0]);

      // single frame, exact line shape and BUSY window edges
      store(A_TX, 32'h0000_00A5);
      s = tx_start;
      run_to(s + FRAME - 1, 1);
      load(A_BUSY); load(A_BUSY); load(A_TXD);

      // dropped stores mid-frame and on the last STOP cycle
      store(A_TX, 32'h0000_0011);
      s = tx_start;
      run_to(s + 49, 0);
      store(A_TX, 32'h0000_0022);
      run_to(s + FRAME - 1, 1);
      store(A_TX, 32'h0000_0033);
      load(A_BUSY); load(A_TXD);
      store(A_TXD, 32'h1); load(A_TXD);
      store(A_TXD, 32'h0); load(A_TXD);

      // completion beats a same-cycle TX_DONE clear
      store(A_TX, $urandom);
      s = tx_start;
      run_to(s + FRAME - 1, 1);
      store(A_TXD, 32'h0);
      load(A_TXD);

      // receive, then load clears RX_DONE
      send_rx(8'h3C, 1'b1, 1'b0);
      load(A_RXD); load(A_RX); load(A_RXD); load(A_RX);

      // glitch and framing error leave receive state alone
      uart_rx = 1'b0;
      repeat (4) tick();
      uart_rx = 1'b1;
      run_to(cyc + 30, 0);
      load(A_RXD);
      send_rx(8'h55, 1'b0, 1'b0);
      load(A_RXD); load(A_RX);

      // overrun, then a load racing the stop sample
      send_rx(8'h01, 1'b1, 1'b0);
      send_rx(8'h02, 1'b1, 1'b0);
      load(A_RXD); load(A_RX);
      send_rx(8'($urandom), 1'b1, 1'b1);
      load(A_RXD); load(A_RX);
      store(A_RXD, 32'h0); load(A_RXD);

      // reset in the middle of a frame, then a fresh frame
      store(A_TX, $urandom);
      s = tx_start;
      run_to(s + 79, 0);
      do_reset();
      load(A_BUSY); load(A_TXD); load(A_RX); load(A_RXD);
      store(A_TX, $urandom);
      s = tx_start;
      run_to(s + FRAME + 1, 1);
      load(A_TXD);

      // randomized traffic
      repeat (8) begin
         store(A_TX, $urandom);
         run_to(cyc + 32'($urandom_range(60, 200)), 2);
         send_rx(8'($urandom), $urandom_range(0, 3) != 0, 1'b0);
         load(A_RXD); load(A_RX); load(A_RXD);
      end
      run_to((tx_start + FRAME + 4 > cyc) ? tx_start + FRAME + 4 : cyc + 4, 0);

      checks++;
      if (rd_q.size() != 0 || ln_q.size() != 0) begin
         errors++;
         $display("FAIL drain got rd=%0d line=%0d pending want 0", rd_q.size(), ln_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
